// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the FIFO packet writer.
package fifo_wr_pkg;

  typedef enum logic {
    WR_STREAM  = 1'b0,
    WR_TRAILER = 1'b1
  } wr_state_e;

  localparam int SKID_DEPTH = 2;
  // Occupancy counts 0..SKID_DEPTH, so it needs one bit more than an index.
  localparam int OCC_W      = 2;

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Upstream stream plus FIFO write port of the packet writer, bundled for port use.
// Handshake: an upstream word moves when s_valid && s_ready at wclk; a FIFO write lands when winc && !wFull at wclk.
interface fifo_pkt_writer_if #(
  parameter int DATA_SIZE = 9,
  parameter int PKT_CNT_W = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 winc;
  logic [DATA_SIZE-1:0] wData;
  logic                 wFull;
  logic                 wHalf_full;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic                 busy;

  modport master (
    input  s_valid, s_data, s_last, wFull, wHalf_full,
    output s_ready, winc, wData, pkt_count, busy
  );

  modport slave (
    output s_valid, s_data, s_last, wFull, wHalf_full,
    input  s_ready, winc, wData, pkt_count, busy
  );
endinterface

// File: rtl/fifo_wr_skid.sv
// Two-entry in-order skid buffer of {data, last}; entry 0 is always the head.
module fifo_wr_skid
  import fifo_wr_pkg::*;
#(
  parameter int DATA_SIZE = 9
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 push_i,
  input  logic [DATA_SIZE-1:0] push_data_i,
  input  logic                 push_last_i,
  input  logic                 pop_i,
  output logic [DATA_SIZE-1:0] head_data_o,
  output logic                 head_last_o,
  output logic [OCC_W-1:0]     occ_o,
  output logic                 ready_o
);

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic                 last;
  } entry_t;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

  entry_t           ent0_q, ent0_d;
  entry_t           ent1_q, ent1_d;
  entry_t           in_ent;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_ent = '{data: push_data_i, last: push_last_i};

  // Callers never push when full nor pop when empty, so those cases are not decoded.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == '0) ent0_d = in_ent;
        else             ent1_d = in_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = in_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data_o = ent0_q.data;
  assign head_last_o = ent0_q.last;
  assign occ_o       = occ_q;
  assign ready_o     = (occ_q != OCC_FULL);

endmodule

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer: streams payload into the async FIFO and appends a word-count trailer.
// Optional FIFO_WR_THROTTLE_EN holds off new packets while the FIFO reports half full.
module fifo_pkt_writer
  import fifo_wr_pkg::*;
#(
  parameter int DATA_SIZE = 9,
  parameter int PKT_CNT_W = 16
) (
  input  logic                wclk,
  input  logic                wrst,
  fifo_pkt_writer_if.master   bus,
  output wr_state_e           dbg_state_o
);

  localparam logic [DATA_SIZE-1:0] CNT_ONE = DATA_SIZE'(1);
  localparam logic [PKT_CNT_W-1:0] PKT_ONE = PKT_CNT_W'(1);

  wr_state_e            state_q, state_d;
  logic [DATA_SIZE-1:0] word_cnt_q, word_cnt_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic                 push, pop, accept, hold_start, winc;
  logic                 s_ready, head_last;
  logic [DATA_SIZE-1:0] head_data;
  logic [OCC_W-1:0]     occ;

  assign push = bus.s_valid && s_ready;

  fifo_wr_skid #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .wclk       (wclk),
    .wrst       (wrst),
    .push_i     (push),
    .push_data_i(bus.s_data),
    .push_last_i(bus.s_last),
    .pop_i      (pop),
    .head_data_o(head_data),
    .head_last_o(head_last),
    .occ_o      (occ),
    .ready_o    (s_ready)
  );

`ifdef FIFO_WR_THROTTLE_EN
  // word_cnt is zero only before the first payload word of a packet is written.
  assign hold_start = (word_cnt_q == '0) && bus.wHalf_full;
`else
  logic unused_half_full;
  assign unused_half_full = bus.wHalf_full;
  assign hold_start       = 1'b0;
`endif

  assign winc   = (state_q == WR_TRAILER) || ((occ != '0) && !hold_start);
  assign accept = winc && !bus.wFull;
  assign pop    = accept && (state_q == WR_STREAM);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      WR_STREAM: begin
        if (pop) begin
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_ONE;
          if (head_last)        state_d    = WR_TRAILER;
        end
      end
      WR_TRAILER: begin
        if (accept) begin
          word_cnt_d  = '0;
          pkt_count_d = pkt_count_q + PKT_ONE;
          state_d     = WR_STREAM;
        end
      end
      default: state_d = WR_STREAM;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q     <= WR_STREAM;
      word_cnt_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.winc      = winc;
  assign bus.wData     = (state_q == WR_TRAILER) ? word_cnt_q : head_data;
  assign bus.pkt_count = pkt_count_q;
  assign bus.busy      = (occ != '0) || (state_q == WR_TRAILER);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer: directed corner sequences, a packet table and random traffic.
module tb_fifo_pkt_writer;
  import fifo_wr_pkg::*;

  localparam int DS = 9;
  localparam int PW = 16;
  localparam logic [DS-1:0] SAT = 9'h1FF;

  logic      wclk = 1'b0;
  logic      wrst = 1'b0;
  wr_state_e dbg_state;

  fifo_pkt_writer_if #(.DATA_SIZE(DS), .PKT_CNT_W(PW)) bus ();

  fifo_pkt_writer #(.DATA_SIZE(DS), .PKT_CNT_W(PW)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [DS-1:0] exp_q[$];
  logic [DS-1:0] wr_log[$];
  int            wr_ts[$];
  int            cur_len   = 0;
  int            pkts_sent = 0;
  logic          rand_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A write is taken by the FIFO at the next edge when winc && !wFull.
  always @(negedge wclk) begin
    if (wrst && bus.winc && !bus.wFull) begin
      logic [DS-1:0] e;
      wr_log.push_back(bus.wData);
      wr_ts.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %0h required none (cycle %0d)", bus.wData, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.wData !== e) begin
          n_err++;
          $display("FAIL write_data: got %0h required %0h (cycle %0d)", bus.wData, e, cyc);
        end
      end
    end
  end

  // Random flow control while rand_en is set.
  always @(posedge wclk) begin
    if (rand_en) begin
      #1;
      bus.wFull      = ($urandom_range(0, 3) == 0);
      bus.wHalf_full = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks ----------------
  // Reference model: payload in push order, then min(length, 2^DS-1).
  task automatic push_word(input logic [DS-1:0] d, input logic last, output int ts);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    ts = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wclk);
      if (bus.s_ready) begin
        ts = cyc;
        break;
      end
    end
    if (ts < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got s_ready=0 required 1 within budget");
    end else begin
      exp_q.push_back(d);
      cur_len++;
      if (last) begin
        exp_q.push_back((cur_len >= 511) ? SAT : DS'(cur_len));
        cur_len = 0;
        pkts_sent++;
      end
    end
    @(posedge wclk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DS-1:0] base, input int gap_max, output int ts0);
    int ts;
    ts0 = -1;
    for (int i = 0; i < len; i++) begin
      push_word(DS'(base + DS'(i)), (i == len - 1), ts);
      if (i == 0) ts0 = ts;
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge wclk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 6000; i++) begin
      @(negedge wclk);
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    chk(name, {31'd0, (exp_q.size() == 0) && !bus.busy}, 32'd1);
    @(posedge wclk);
    #1;
  endtask

  // ---------------- packet table ----------------
  typedef struct {
    int        len;
    logic [DS-1:0] base;
    int        gap;
    logic      half;
    logic [DS-1:0] exp_tr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ts, ts0, i0;

    vecs[0] = '{len: 1,   base: 9'h1F0, gap: 0, half: 1'b1, exp_tr: 9'h001};
    vecs[1] = '{len: 2,   base: 9'h010, gap: 2, half: 1'b0, exp_tr: 9'h002};
    vecs[2] = '{len: 5,   base: 9'h1FE, gap: 1, half: 1'b1, exp_tr: 9'h005};
    vecs[3] = '{len: 7,   base: 9'h100, gap: 0, half: 1'b0, exp_tr: 9'h007};
    vecs[4] = '{len: 511, base: 9'h000, gap: 0, half: 1'b0, exp_tr: 9'h1FF};
    vecs[5] = '{len: 512, base: 9'h055, gap: 0, half: 1'b0, exp_tr: 9'h1FF};
    vecs[6] = '{len: 600, base: 9'h123, gap: 0, half: 1'b0, exp_tr: 9'h1FF};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.wFull = 1'b0; bus.wHalf_full = 1'b0;
    wrst = 1'b0;
    repeat (3) @(posedge wclk);
    #1;

    // Reset values while held
    chk("rst_winc",   bus.winc,      0);
    chk("rst_wdata",  bus.wData,     0);
    chk("rst_sready", bus.s_ready,   1);
    chk("rst_pkts",   bus.pkt_count, 0);
    chk("rst_busy",   bus.busy,      0);
    wrst = 1'b1;
    @(posedge wclk);
    #1;

    // Single packet: 011, 022, 033(last) -> four writes on consecutive cycles
    i0 = wr_log.size();
    push_word(9'h011, 1'b0, ts0);
    push_word(9'h022, 1'b0, ts);
    push_word(9'h033, 1'b1, ts);
    drain("single_drain");
    chk("single_nwr", wr_log.size() - i0, 4);
    if (wr_log.size() - i0 == 4) begin
      for (int k = 0; k < 4; k++) chk("single_ts", wr_ts[i0 + k], ts0 + 1 + k);
      chk("single_trailer", wr_log[i0 + 3], 9'h003);
    end
    chk("single_pkts", bus.pkt_count, 1);

    // Back-to-back packets: no idle cycle between trailer and next packet
    i0 = wr_log.size();
    push_word(9'h0A1, 1'b0, ts);
    push_word(9'h0A2, 1'b1, ts);
    push_word(9'h0B1, 1'b0, ts);
    push_word(9'h0B2, 1'b1, ts);
    drain("b2b_drain");
    chk("b2b_nwr", wr_log.size() - i0, 6);
    if (wr_log.size() - i0 == 6)
      for (int k = 1; k < 6; k++) chk("b2b_ts", wr_ts[i0 + k], wr_ts[i0] + k);
    chk("b2b_pkts", bus.pkt_count, 3);

    // Backpressure: wFull for 5 cycles while a 4-word packet arrives
    i0 = wr_log.size();
    bus.wFull = 1'b1;
    fork
      begin
        push_word(9'h101, 1'b0, ts);
        push_word(9'h102, 1'b0, ts);
        push_word(9'h103, 1'b0, ts);
        push_word(9'h104, 1'b1, ts);
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge wclk);
          if (k >= 2) begin
            chk("bp_winc_held",  bus.winc,  1);
            chk("bp_wdata_held", bus.wData, 9'h101);
          end
          if (k == 3) chk("bp_sready_drop", bus.s_ready, 0);
        end
        @(posedge wclk);
        #1;
        bus.wFull = 1'b0;
      end
    join
    drain("bp_drain");
    chk("bp_nwr", wr_log.size() - i0, 5);
    if (wr_log.size() - i0 == 5) chk("bp_trailer", wr_log[i0 + 4], 9'h004);
    chk("bp_pkts", bus.pkt_count, 4);

    // Stall during the trailer of a 1-word packet
    i0 = wr_log.size();
    push_word(9'h0AA, 1'b1, ts);
    @(posedge wclk);
    #1;
    bus.wFull = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      chk("tr_state", dbg_state, WR_TRAILER);
      chk("tr_winc",  bus.winc,  1);
      chk("tr_wdata", bus.wData, 9'h001);
      chk("tr_pkts_hold", bus.pkt_count, pkts_sent - 1);
    end
    @(posedge wclk);
    #1;
    bus.wFull = 1'b0;
    drain("tr_drain");
    chk("tr_nwr", wr_log.size() - i0, 2);
    chk("tr_pkts", bus.pkt_count, pkts_sent);

    // Packet table, including counter saturation
    for (int v = 0; v < 7; v++) begin
      i0 = wr_log.size();
`ifdef FIFO_WR_THROTTLE_EN
      bus.wHalf_full = 1'b0;
`else
      bus.wHalf_full = vecs[v].half;
`endif
      send_pkt(vecs[v].len, vecs[v].base, vecs[v].gap, ts0);
      drain("vec_drain");
      bus.wHalf_full = 1'b0;
      chk("vec_nwr", wr_log.size() - i0, vecs[v].len + 1);
      chk("vec_trailer", wr_log[wr_log.size() - 1], vecs[v].exp_tr);
      chk("vec_pkts", bus.pkt_count, pkts_sent[15:0]);
    end

`ifdef FIFO_WR_THROTTLE_EN
    // Half-full at packet start holds the packet back
    i0 = wr_log.size();
    bus.wHalf_full = 1'b1;
    push_word(9'h0C1, 1'b0, ts);
    push_word(9'h0C2, 1'b1, ts);
    repeat (4) begin
      @(negedge wclk);
      chk("thr_hold", bus.winc, 0);
    end
    @(posedge wclk);
    #1;
    bus.wHalf_full = 1'b0;
    drain("thr_drain");
    chk("thr_nwr", wr_log.size() - i0, 3);

    // Half-full rising mid-packet does not pause it
    i0 = wr_log.size();
    fork
      begin
        push_word(9'h0D1, 1'b0, ts);
        push_word(9'h0D2, 1'b0, ts);
        push_word(9'h0D3, 1'b1, ts);
      end
      begin
        for (int k = 0; k < 50 && wr_log.size() == i0; k++) @(posedge wclk);
        #1;
        bus.wHalf_full = 1'b1;
      end
    join
    drain("thr_mid_drain");
    bus.wHalf_full = 1'b0;
    chk("thr_mid_nwr", wr_log.size() - i0, 4);
    if (wr_log.size() - i0 == 4)
      for (int k = 1; k < 4; k++) chk("thr_mid_ts", wr_ts[i0 + k], wr_ts[i0] + k);
`endif

    // Random packets under random wFull / wHalf_full
    rand_en = 1'b1;
    for (int p = 0; p < 40; p++)
      send_pkt($urandom_range(1, 8), DS'($urandom), 3, ts0);
    rand_en = 1'b0;
    @(posedge wclk);
    #2;
    bus.wFull = 1'b0;
    bus.wHalf_full = 1'b0;
    drain("rand_drain");
    chk("rand_pkts", bus.pkt_count, pkts_sent[15:0]);

    // Reset mid-packet with two buffered words: nothing survives
    bus.wFull = 1'b1;
    push_word(9'h0E1, 1'b0, ts);
    push_word(9'h0E2, 1'b0, ts);
    chk("mid_occ2", bus.s_ready, 0);
    wrst = 1'b0;
    #1;
    chk("mid_rst_winc",   bus.winc,      0);
    chk("mid_rst_wdata",  bus.wData,     0);
    chk("mid_rst_sready", bus.s_ready,   1);
    chk("mid_rst_pkts",   bus.pkt_count, 0);
    chk("mid_rst_busy",   bus.busy,      0);
    exp_q.delete();
    cur_len   = 0;
    pkts_sent = 0;
    bus.wFull = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b1;
    i0 = wr_log.size();
    repeat (10) @(negedge wclk);
    chk("mid_no_stale", wr_log.size() - i0, 0);
    chk("mid_idle_busy", bus.busy, 0);
    @(posedge wclk);
    #1;
    push_word(9'h077, 1'b1, ts);
    drain("post_rst_drain");
    chk("post_rst_nwr", wr_log.size() - i0, 2);
    chk("post_rst_pkts", bus.pkt_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_writer.md
# fifo_pkt_writer

Write-side packet framer for the asynchronous FIFO, in the wclk domain. Accepts packets from an upstream valid/ready stream and drives the FIFO write port (winc, wData). Honours wFull. After each packet's last payload word, appends one trailer word that holds the packet's payload word count, so the read side can check framing.

## Interface
- DATA_SIZE, 9: payload and FIFO word width; the trailer count is also this wide.
- PKT_CNT_W, 16: width of the completed-packet counter.

Ports:
- wclk  input  1  write-domain clock
- wrst  input  1  reset, asynchronous, active-low
- s_valid  input  1  upstream word valid
- s_ready  output  1  upstream may push this cycle
- s_data  input  DATA_SIZE  upstream payload word
- s_last  input  1  marks the final payload word of a packet
- winc  output  1  FIFO write request
- wData  output  DATA_SIZE  FIFO write data
- wFull  input  1  FIFO full (registered, wclk domain)
- wHalf_full  input  1  FIFO half-full flag
- pkt_count  output  PKT_CNT_W  count of completed packets, trailer included, wraps
- busy  output  1  buffered data or a pending trailer exists

## Operation
- **Input buffer:** 2-entry FIFO-ordered skid buffer holding {data, last}, with occupancy occ in 0..2.
  - s_ready = (occ != 2), driven only from registered state. There is no combinational path from wFull or s_valid to s_ready.
  - A push occurs when s_valid && s_ready.
- **Write acceptance:** a FIFO write is accepted when winc && !wFull at the wclk edge. When wFull=1 the FIFO discards the write, so the writer holds winc and wData unchanged until the write is accepted.
- **State machine:** states WR_STREAM and WR_TRAILER.
  - WR_STREAM:
    - winc = (occ != 0); wData = head data.
    - On accept: pop the head and increment word_cnt, saturating at 2^DATA_SIZE-1.
    - If the popped head has last=1, go to WR_TRAILER.
  - WR_TRAILER:
    - winc = 1; wData = word_cnt, the payload word count including the last word.
    - On accept: word_cnt <= 0, pkt_count += 1, go to WR_STREAM.
    - Pushes into the skid buffer continue during this state.
- **Simultaneous push and pop:** occ is unchanged and order is preserved.
  - At occ=0, data pushed in cycle N appears on wData in cycle N+1; there is no bypass.
- **busy** = (occ != 0) || (state == WR_TRAILER).
- **Reset values:** occ=0, buffer contents 0, state WR_STREAM, word_cnt=0, pkt_count=0, so winc=0, wData=0, s_ready=1, busy=0.
- **Reset mid-packet:** the partial packet and any pending trailer are lost. No trailer is emitted.

## Timing
- Latency from an upstream push to winc is 1 cycle when the buffer is empty and the FIFO is not full.
- Sustained throughput is 1 word per cycle while the FIFO is not full.
- Each packet costs one extra cycle for its trailer.
- Back-to-back packets: the first word of the next packet is written in the cycle after the trailer is accepted.
- A 1-word packet produces two writes: the payload word, then trailer value 1.
- wFull asserted for K cycles stalls the current word (payload or trailer) for exactly K cycles. Nothing is duplicated or dropped.

## Configuration
- **FIFO_WR_THROTTLE_EN defined:** in WR_STREAM with word_cnt == 0 (packet start), winc is forced to 0 while wHalf_full=1.
  - A new packet does not start while the FIFO is half full.
  - Packets already in progress and pending trailers are unaffected.
- **Not defined:** wHalf_full is ignored.

## Structure
- Package fifo_wr_pkg holds:
  - typedef enum logic wr_state_e {WR_STREAM, WR_TRAILER};
  - localparam SKID_DEPTH = 2.
- Sub-module fifo_wr_skid: the 2-entry {data, last} skid buffer.
  - Exposes push/pop, head, occ and s_ready.
  - fifo_pkt_writer contains the state machine, counters and the winc/wData mux.

## Test plan
- **Reset:** assert wrst=0 mid-packet with occ=2 -> winc=0, wData=0, s_ready=1, pkt_count=0, busy=0 while reset is held. After release, no stale trailer is emitted.
- **Single packet:** push 0x011, 0x022, 0x033 (last), wFull=0 -> FIFO receives 0x011, 0x022, 0x033, 0x003 on consecutive cycles; pkt_count=1.
- **Backpressure:** hold wFull=1 for 5 cycles while a 4-word packet streams in -> s_ready drops after 2 pushes, wData stays constant through the stall, and the FIFO receives all 4 words in order plus trailer 0x004.
- **Stall during trailer:** wFull=1 in the trailer cycle for 3 cycles -> the trailer is held, then written once; pkt_count increments exactly once.
- **Saturation:** a 600-word packet with DATA_SIZE=9 -> trailer = 0x1FF.
- **Throttle (FIFO_WR_THROTTLE_EN):** wHalf_full=1 at packet start -> winc stays 0 until wHalf_full=0. wHalf_full rising mid-packet -> the packet and its trailer complete without pause.
